// File: rtl/cnt_led.sv
// ============================================================================
// Module      : cnt_led
// Description : Free-running LED blinker; toggles led every CNT_MAX+1 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_led #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int HALF_PERIOD_MS = 500,
    parameter int CNT_MAX        = CLK_FREQ_HZ / 1000 * HALF_PERIOD_MS - 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      led
);

    // Width is derived from the terminal count; the guard keeps it legal
    // while the range check below reports an illegal CNT_MAX.
    localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    if (CNT_MAX < 1) begin : g_bad_cnt_max
        $error("cnt_led: CNT_MAX must be >= 1");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             r_led;
    logic             w_tc;

    assign w_tc = (r_cnt == C_CNT_MAX);

    // Using >= also pulls any unreachable out-of-range value back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt >= C_CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else if (w_tc) begin
            r_led <= ~r_led;
        end
    end

    assign led = r_led;

endmodule

`default_nettype wire

// File: tb/tb_cnt_led.sv
// ============================================================================
// Module      : tb_cnt_led
// Description : Directed self-checking bench for cnt_led over several configs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_led;

    logic clk;
    logic rst_n;
    logic led_a;   // CNT_MAX = 9
    logic led_e;   // CNT_MAX = 1
    logic led_d;   // default parameters
    logic led_f;   // derived: 20 kHz, 500 ms -> CNT_MAX = 9999

    int n_vec;
    int n_err;

    cnt_led #(.CNT_MAX(9)) dut_a (.clk(clk), .rst_n(rst_n), .led(led_a));
    cnt_led #(.CNT_MAX(1)) dut_e (.clk(clk), .rst_n(rst_n), .led(led_e));
    cnt_led                dut_d (.clk(clk), .rst_n(rst_n), .led(led_d));
    cnt_led #(.CLK_FREQ_HZ(20_000), .HALF_PERIOD_MS(500))
                           dut_f (.clk(clk), .rst_n(rst_n), .led(led_f));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected state after k edges since release for a given CNT_MAX.
    task automatic check_run(input int k);
        check("a_cnt", 32'(dut_a.r_cnt), 32'(k % 10));
        check("a_led", 32'(led_a),       32'((k / 10) % 2));
        check("e_cnt", 32'(dut_e.r_cnt), 32'(k % 2));
        check("e_led", 32'(led_e),       32'((k / 2) % 2));
    endtask

    initial begin
        int toggles;
        int toggle_at;
        logic prev_f;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;

        // Reset held with the clock running.
        #50;
        check("rst_a_led", 32'(led_a), 32'd0);
        check("rst_a_cnt", 32'(dut_a.r_cnt), 32'd0);
        check("rst_e_led", 32'(led_e), 32'd0);
        check("rst_d_led", 32'(led_d), 32'd0);
        check("rst_d_cnt", 32'(dut_d.r_cnt), 32'd0);
        check("rst_f_led", 32'(led_f), 32'd0);
        #50;
        rst_n = 1'b1;

        // First toggle, steady state, CNT_MAX=1 edge case, default counting.
        for (int k = 1; k <= 115; k++) begin
            tick();
            check_run(k);
            if (k <= 20) begin
                check("d_cnt", 32'(dut_d.r_cnt), 32'(k));
                check("d_led", 32'(led_d), 32'd0);
            end
        end

        // Now cnt_a=5, led_a=1: async reset between edges.
        #5;
        rst_n = 1'b0;
        #1;
        check("async_a_led", 32'(led_a), 32'd0);
        check("async_a_cnt", 32'(dut_a.r_cnt), 32'd0);
        check("async_e_cnt", 32'(dut_e.r_cnt), 32'd0);
        check("async_d_cnt", 32'(dut_d.r_cnt), 32'd0);
        #20;
        rst_n = 1'b1;

        // Full interval restarts; also track the derived-parameter instance.
        toggles   = 0;
        toggle_at = -1;
        prev_f    = led_f;
        for (int k = 1; k <= 15000; k++) begin
            tick();
            if (k <= 25) check_run(k);
            if (led_f !== prev_f) begin
                toggles++;
                if (toggle_at < 0) toggle_at = k;
            end
            prev_f = led_f;
            if (k == 9999) begin
                check("f_cnt_pre", 32'(dut_f.r_cnt), 32'd9999);
                check("f_led_pre", 32'(led_f), 32'd0);
            end
            if (k == 10000) begin
                check("f_cnt_wrap", 32'(dut_f.r_cnt), 32'd0);
                check("f_led_tgl", 32'(led_f), 32'd1);
            end
            if (k == 15000) begin
                check("d_cnt_long", 32'(dut_d.r_cnt), 32'd15000);
                check("d_led_long", 32'(led_d), 32'd0);
            end
        end
        check("f_toggle_edge", 32'(toggle_at), 32'd10000);
        check("f_toggle_count", 32'(toggles), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
